subtract_mean_axis_stall_detector: RTL and testbench

- Generates the per-stream AXI-Stream block indications that the subtract_mean deadlock monitor consumes.
- Watches the handshake (tvalid/tready) of every subtract_mean AXIS port and times consecutive stalled cycles per channel.
- Asserts a registered per-channel block flag once a stall persists for THRESH cycles.
- Keeps sticky status and the index of the first channel to block, for debug readback.

---
 rtl/subtract_mean_axis_stall_detector.sv | 158 +++++++++++++++
 tb/tb_subtract_mean_axis_stall_detector.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/subtract_mean_axis_stall_detector.sv
// Per-channel AXIS stall timers producing registered block flags for the subtract_mean deadlock monitor.
// Optional SUBTRACT_MEAN_STALL_PEAK_EN adds per-channel peak stall-count readback.

module subtract_mean_stall_ch #(
  parameter int CNT_W  = 16,
  parameter int THRESH = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
  input  logic             clear,
  output logic [CNT_W-1:0] peak,
`endif
  input  logic             stall,
  output logic             block,
  output logic             enter
);
  typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, BLOCKED = 2'd2} state_t;

  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               THR_ONE = (THRESH == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);
  // Entry into BLOCKED this cycle; feeds sticky and first-block capture.
  assign enter = stall & (((state == IDLE) && THR_ONE) ||
                          ((state == STALL) && (cnt_inc == THR)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      block <= 1'b0;
    end else if (!stall) begin
      state <= IDLE;
      cnt   <= '0;
      block <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= CNT_W'(1);
          if (THR_ONE) begin
            state <= BLOCKED;
            block <= 1'b1;
          end else begin
            state <= STALL;
          end
        end
        STALL: begin
          cnt <= cnt_inc;
          if (cnt_inc == THR) begin
            state <= BLOCKED;
            block <= 1'b1;
          end
        end
        BLOCKED: begin
          if (cnt != CNT_MAX) cnt <= cnt_inc;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          block <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
  logic [CNT_W-1:0] peak_base;
  assign peak_base = clear ? '0 : peak;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               peak <= '0;
    else if (cnt > peak_base)   peak <= cnt;
    else                        peak <= peak_base;
  end
`endif
endmodule

module subtract_mean_axis_stall_detector #(
  parameter int                NUM_CH   = 3,
  parameter int                CNT_W    = 16,
  parameter int                THRESH   = 1024,
  parameter logic [NUM_CH-1:0] DIR_MASK = 3'b100
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic                                       enable,
  input  logic                                       clear,
  input  logic [NUM_CH-1:0]                          ch_tvalid,
  input  logic [NUM_CH-1:0]                          ch_tready,
  output logic [NUM_CH-1:0]                          axis_block_sigs,
  output logic                                       block_any,
  output logic [NUM_CH-1:0]                          sticky_block,
  output logic                                       first_vld,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] first_idx
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]                    peak_stall
`endif
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] enter;
  logic [IDX_W-1:0]  low_idx;
  logic              base_vld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Producers stall on backpressure, consumers stall on starvation.
    assign stall[i] = enable & (DIR_MASK[i] ? (ch_tvalid[i] & ~ch_tready[i])
                                            : (ch_tready[i] & ~ch_tvalid[i]));

    subtract_mean_stall_ch #(.CNT_W(CNT_W), .THRESH(THRESH)) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
      .clear   (clear),
      .peak    (peak_stall[i*CNT_W +: CNT_W]),
`endif
      .stall   (stall[i]),
      .block   (axis_block_sigs[i]),
      .enter   (enter[i])
    );
  end

  assign block_any = |axis_block_sigs;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (enter[i]) low_idx = IDX_W'(i);
  end

  // Clear acts first so a same-cycle entry is still captured.
  assign base_vld = first_vld & ~clear;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_block <= '0;
      first_vld    <= 1'b0;
      first_idx    <= '0;
    end else begin
      sticky_block <= (clear ? '0 : sticky_block) | enter;
      if (!base_vld && (|enter)) begin
        first_vld <= 1'b1;
        first_idx <= low_idx;
      end else begin
        first_vld <= base_vld;
        first_idx <= clear ? '0 : first_idx;
      end
    end
  end
endmodule

// File: tb/tb_subtract_mean_axis_stall_detector.sv
// Scoreboard bench: steps push expected post-edge state, a monitor pops and compares after each edge.
module tb_subtract_mean_axis_stall_detector;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // DUT A: THRESH=4, CNT_W=16
  logic       en, clr;
  logic [2:0] v, r;
  logic [2:0] a_blk, a_sticky;
  logic       a_any, a_fvld;
  logic [1:0] a_fidx;
  // DUT B: CNT_W=4, THRESH=3 (saturation)
  logic       b_en, b_clr;
  logic [2:0] b_v, b_r;
  logic [2:0] b_blk, b_sticky;
  logic       b_any, b_fvld;
  logic [1:0] b_fidx;
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
  logic [47:0] a_peak;
  logic [11:0] b_peak;
`endif

  subtract_mean_axis_stall_detector #(.NUM_CH(3), .CNT_W(16), .THRESH(4), .DIR_MASK(3'b100)) u_a (
    .clock(clock), .reset_n(reset_n), .enable(en), .clear(clr),
    .ch_tvalid(v), .ch_tready(r),
    .axis_block_sigs(a_blk), .block_any(a_any), .sticky_block(a_sticky),
    .first_vld(a_fvld), .first_idx(a_fidx)
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
    , .peak_stall(a_peak)
`endif
  );

  subtract_mean_axis_stall_detector #(.NUM_CH(3), .CNT_W(4), .THRESH(3), .DIR_MASK(3'b100)) u_b (
    .clock(clock), .reset_n(reset_n), .enable(b_en), .clear(b_clr),
    .ch_tvalid(b_v), .ch_tready(b_r),
    .axis_block_sigs(b_blk), .block_any(b_any), .sticky_block(b_sticky),
    .first_vld(b_fvld), .first_idx(b_fidx)
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
    , .peak_stall(b_peak)
`endif
  );

  typedef struct {
    int         kind;   // 0 skip, 1 check A, 2 check B
    string      name;
    logic [2:0] blk;
    logic [2:0] sticky;
    logic       fvld;
    logic [1:0] fidx;
    logic       blk0;
    bit         pk_chk;
    logic [3:0] pk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: one pop per rising edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.kind == 1) begin
          cmp({e.name, ".blk"},    32'(a_blk),    32'(e.blk));
          cmp({e.name, ".any"},    32'(a_any),    32'(|e.blk));
          cmp({e.name, ".sticky"}, 32'(a_sticky), 32'(e.sticky));
          cmp({e.name, ".fvld"},   32'(a_fvld),   32'(e.fvld));
          cmp({e.name, ".fidx"},   32'(a_fidx),   32'(e.fidx));
        end else if (e.kind == 2) begin
          cmp({e.name, ".blk0"}, 32'(b_blk[0]), 32'(e.blk0));
`ifdef SUBTRACT_MEAN_STALL_PEAK_EN
          if (e.pk_chk) cmp({e.name, ".peak0"}, 32'(b_peak[3:0]), 32'(e.pk));
`endif
        end
      end
    end
  end

  task automatic step_a(input logic [2:0] tv, tr, input logic e, c, input int kind, input string nm,
                        input logic [2:0] eb, es, input logic ef, input logic [1:0] ei);
    exp_t x;
    @(negedge clock);
    v = tv; r = tr; en = e; clr = c;
    x.kind = kind; x.name = nm; x.blk = eb; x.sticky = es; x.fvld = ef; x.fidx = ei;
    x.blk0 = 1'b0; x.pk_chk = 1'b0; x.pk = '0;
    sb.push_back(x);
  endtask

  task automatic step_b(input logic [2:0] tv, tr, input logic c, input string nm,
                        input logic eb0, input bit pkc, input logic [3:0] epk);
    exp_t x;
    @(negedge clock);
    b_v = tv; b_r = tr; b_en = 1'b1; b_clr = c;
    x.kind = 2; x.name = nm; x.blk = '0; x.sticky = '0; x.fvld = 1'b0; x.fidx = '0;
    x.blk0 = eb0; x.pk_chk = pkc; x.pk = epk;
    sb.push_back(x);
  endtask

  initial begin
    en = 0; clr = 0; v = 0; r = 0;
    b_en = 0; b_clr = 0; b_v = 0; b_r = 0;
    #12;
    cmp("reset.blk", 32'(a_blk), 0);
    cmp("reset.sticky", 32'(a_sticky), 0);
    cmp("reset.fvld", 32'(a_fvld), 0);
    @(negedge clock); reset_n = 1'b1;

    // ch0 starved 4 cycles -> blocks, then recovers
    for (int k = 1; k <= 3; k++) step_a(3'b000, 3'b001, 1, 0, 1, "t1.pre", 3'b000, 3'b000, 0, 0);
    step_a(3'b000, 3'b001, 1, 0, 1, "t1.blk", 3'b001, 3'b001, 1, 0);
    step_a(3'b000, 3'b001, 1, 0, 1, "t1.hold", 3'b001, 3'b001, 1, 0);
    step_a(3'b000, 3'b000, 1, 0, 1, "t1.drop", 3'b000, 3'b001, 1, 0);
    step_a(3'b000, 3'b000, 1, 1, 1, "t1.clr", 3'b000, 3'b000, 0, 0);

    // ch2 backpressured 3 cycles, transfer, 3 more: counter must restart
    for (int k = 1; k <= 3; k++) step_a(3'b100, 3'b000, 1, 0, 1, "t2.a", 3'b000, 3'b000, 0, 0);
    step_a(3'b100, 3'b100, 1, 0, 1, "t2.xfer", 3'b000, 3'b000, 0, 0);
    for (int k = 1; k <= 3; k++) step_a(3'b100, 3'b000, 1, 0, 1, "t2.b", 3'b000, 3'b000, 0, 0);
    step_a(3'b000, 3'b000, 1, 0, 1, "t2.idle", 3'b000, 3'b000, 0, 0);

    // ch0+ch1 together; ch0 recovers; then enable drops with ch1 still stalled
    for (int k = 1; k <= 3; k++) step_a(3'b000, 3'b011, 1, 0, 1, "t3.pre", 3'b000, 3'b000, 0, 0);
    step_a(3'b000, 3'b011, 1, 0, 1, "t3.blk", 3'b011, 3'b011, 1, 0);
    step_a(3'b000, 3'b010, 1, 0, 1, "t3.ch0rec", 3'b010, 3'b011, 1, 0);
    step_a(3'b000, 3'b010, 0, 0, 1, "t4.endis", 3'b000, 3'b011, 1, 0);
    step_a(3'b000, 3'b010, 0, 1, 1, "t4.clr", 3'b000, 3'b000, 0, 0);

    // clear together with ch1 entry: entry captured
    for (int k = 1; k <= 3; k++) step_a(3'b000, 3'b010, 1, 0, 1, "t5.pre", 3'b000, 3'b000, 0, 0);
    step_a(3'b000, 3'b010, 1, 1, 1, "t5.clrset", 3'b010, 3'b010, 1, 1);
    step_a(3'b000, 3'b000, 1, 0, 1, "t5.idle", 3'b000, 3'b010, 1, 1);
    // later ch0 block must not move first_idx
    for (int k = 1; k <= 3; k++) step_a(3'b000, 3'b001, 1, 0, 1, "t6.pre", 3'b000, 3'b010, 1, 1);
    step_a(3'b000, 3'b001, 1, 0, 1, "t6.blk", 3'b001, 3'b011, 1, 1);

    // asynchronous reset mid-BLOCKED
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    cmp("arst.blk", 32'(a_blk), 0);
    cmp("arst.any", 32'(a_any), 0);
    cmp("arst.sticky", 32'(a_sticky), 0);
    cmp("arst.fvld", 32'(a_fvld), 0);
    cmp("arst.fidx", 32'(a_fidx), 0);
    @(negedge clock);
    en = 0; v = 0; r = 0;
    reset_n = 1'b1;

    // saturation on DUT B: 40-cycle ch0 stall
    for (int k = 1; k <= 40; k++)
      step_b(3'b000, 3'b001, 0, "t7.hold", (k >= 3), (k >= 17), 4'd15);
    step_b(3'b000, 3'b000, 0, "t7.rec", 0, 1, 4'd15);
    step_b(3'b000, 3'b000, 1, "t7.clr", 0, 1, 4'd0);

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
